// File: rtl/nios2_mult_cell_pipe.sv
// Pipelined multiply cell: configurable-width operands travel through a delay chain
// into a partial-product stage, then a combine stage builds the full double-width product.
module nios2_mult_cell_pipe #(
    parameter int DATA_W      = 32,
    parameter int MULT_STAGES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_valid,
    input  logic              E_signed_a,
    input  logic              E_signed_b,
    input  logic              M_en,
    input  logic              M_flush,
    output logic [DATA_W-1:0] M_mul_cell_p1,
    output logic [DATA_W-1:0] M_mul_cell_p2,
    output logic [DATA_W-1:0] M_mul_cell_p3,
    output logic              M_pp_valid,
    output logic [DATA_W-1:0] M_mul_lo,
    output logic [DATA_W-1:0] M_mul_hi,
    output logic              M_mul_valid
);

    localparam int H  = DATA_W / 2;
    localparam int SW = 2 * DATA_W + 3;

    // Handshake: an operation is accepted on a rising edge when E_valid=1, M_en=1 and
    // M_flush=0; each stage's valid bit qualifies its data, and M_en=0 freezes every stage.
    // Stage word layout: {valid, signed_a, signed_b, a, b}. Data only loads behind a live token,
    // so idle outputs keep their last (or reset) value.
    logic [SW-1:0] issue_word;
    logic [SW-1:0] pp_in;

    assign issue_word = {E_valid & ~M_flush, E_signed_a, E_signed_b, E_src1, E_src2};

    generate
        if (MULT_STAGES == 1) begin : g_no_dly
            assign pp_in = issue_word;
        end else begin : g_dly
            logic [SW-1:0] dly [MULT_STAGES-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < MULT_STAGES - 1; i++) dly[i] <= '0;
                end else begin
                    if (M_en && issue_word[SW-1]) dly[0][SW-2:0] <= issue_word[SW-2:0];
                    if (M_en) dly[0][SW-1] <= issue_word[SW-1];
                    for (int i = 1; i < MULT_STAGES - 1; i++) begin
                        if (M_en && dly[i-1][SW-1]) dly[i][SW-2:0] <= dly[i-1][SW-2:0];
                        if (M_en) dly[i][SW-1] <= dly[i-1][SW-1];
                    end
                    if (M_flush) begin
                        for (int i = 0; i < MULT_STAGES - 1; i++) dly[i][SW-1] <= 1'b0;
                    end
                end
            end

            assign pp_in = dly[MULT_STAGES-2];
        end
    endgenerate

    logic              in_v, in_sa, in_sb;
    logic [DATA_W-1:0] in_a, in_b;
    logic [DATA_W-1:0] prod_ll, prod_lh, prod_hl, prod_hh;

    assign {in_v, in_sa, in_sb, in_a, in_b} = pp_in;

    assign prod_ll = {{H{1'b0}}, in_a[H-1:0]}      * {{H{1'b0}}, in_b[H-1:0]};
    assign prod_lh = {{H{1'b0}}, in_a[H-1:0]}      * {{H{1'b0}}, in_b[DATA_W-1:H]};
    assign prod_hl = {{H{1'b0}}, in_a[DATA_W-1:H]} * {{H{1'b0}}, in_b[H-1:0]};
    assign prod_hh = {{H{1'b0}}, in_a[DATA_W-1:H]} * {{H{1'b0}}, in_b[DATA_W-1:H]};

    // The hi*hi product and the raw operands ride along for the signed correction.
    logic [DATA_W-1:0] pp_hh, pp_a, pp_b;
    logic              pp_sa, pp_sb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            M_mul_cell_p1 <= '0;
            M_mul_cell_p2 <= '0;
            M_mul_cell_p3 <= '0;
            pp_hh         <= '0;
            pp_a          <= '0;
            pp_b          <= '0;
            pp_sa         <= 1'b0;
            pp_sb         <= 1'b0;
            M_pp_valid    <= 1'b0;
        end else begin
            if (M_en && in_v) begin
                M_mul_cell_p1 <= prod_ll;
                M_mul_cell_p2 <= prod_lh;
                M_mul_cell_p3 <= prod_hl;
                pp_hh         <= prod_hh;
                pp_a          <= in_a;
                pp_b          <= in_b;
                pp_sa         <= in_sa;
                pp_sb         <= in_sb;
            end
            if (M_flush)   M_pp_valid <= 1'b0;
            else if (M_en) M_pp_valid <= in_v;
        end
    end

    // Unsigned product first; a negative signed operand X contributes -(other << DATA_W),
    // which only touches the upper half modulo 2^(2*DATA_W).
    logic [2*DATA_W-1:0] sum_u;
    logic [DATA_W-1:0]   corr;
    logic [DATA_W-1:0]   full_hi;

    always_comb begin
        sum_u = {pp_hh, M_mul_cell_p1}
              + {{H{1'b0}}, M_mul_cell_p2, {H{1'b0}}}
              + {{H{1'b0}}, M_mul_cell_p3, {H{1'b0}}};
        corr = '0;
        if (pp_sa && pp_a[DATA_W-1]) corr = pp_b;
        if (pp_sb && pp_b[DATA_W-1]) corr = corr + pp_a;
        full_hi = sum_u[2*DATA_W-1:DATA_W] - corr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            M_mul_lo    <= '0;
            M_mul_hi    <= '0;
            M_mul_valid <= 1'b0;
        end else begin
            if (M_en && M_pp_valid) begin
                M_mul_lo <= sum_u[DATA_W-1:0];
                M_mul_hi <= full_hi;
            end
            if (M_flush)   M_mul_valid <= 1'b0;
            else if (M_en) M_mul_valid <= M_pp_valid;
        end
    end

endmodule

// File: tb/tb_nios2_mult_cell_pipe.sv
// Bench for nios2_mult_cell_pipe: four instances (32/1, 32/2, 16/3, 8/1) share one stimulus
// stream; directed scenarios plus a randomized sweep against a queue-based reference model.
module tb_nios2_mult_cell_pipe;

    logic        clk;
    logic        reset_n;
    logic [31:0] src1, src2;
    logic        e_valid, sa, sb, m_en, m_flush;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] a_p1, a_p2, a_p3, a_lo, a_hi;
    logic        a_ppv, a_mv;
    logic [31:0] b_p1, b_p2, b_p3, b_lo, b_hi;
    logic        b_ppv, b_mv;
    logic [15:0] c_p1, c_p2, c_p3, c_lo, c_hi;
    logic        c_ppv, c_mv;
    logic [7:0]  d_p1, d_p2, d_p3, d_lo, d_hi;
    logic        d_ppv, d_mv;

    nios2_mult_cell_pipe #(.DATA_W(32), .MULT_STAGES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .E_src1(src1), .E_src2(src2), .E_valid(e_valid),
        .E_signed_a(sa), .E_signed_b(sb), .M_en(m_en), .M_flush(m_flush),
        .M_mul_cell_p1(a_p1), .M_mul_cell_p2(a_p2), .M_mul_cell_p3(a_p3), .M_pp_valid(a_ppv),
        .M_mul_lo(a_lo), .M_mul_hi(a_hi), .M_mul_valid(a_mv));

    nios2_mult_cell_pipe #(.DATA_W(32), .MULT_STAGES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .E_src1(src1), .E_src2(src2), .E_valid(e_valid),
        .E_signed_a(sa), .E_signed_b(sb), .M_en(m_en), .M_flush(m_flush),
        .M_mul_cell_p1(b_p1), .M_mul_cell_p2(b_p2), .M_mul_cell_p3(b_p3), .M_pp_valid(b_ppv),
        .M_mul_lo(b_lo), .M_mul_hi(b_hi), .M_mul_valid(b_mv));

    nios2_mult_cell_pipe #(.DATA_W(16), .MULT_STAGES(3)) dut_c (
        .clk(clk), .reset_n(reset_n), .E_src1(src1[15:0]), .E_src2(src2[15:0]), .E_valid(e_valid),
        .E_signed_a(sa), .E_signed_b(sb), .M_en(m_en), .M_flush(m_flush),
        .M_mul_cell_p1(c_p1), .M_mul_cell_p2(c_p2), .M_mul_cell_p3(c_p3), .M_pp_valid(c_ppv),
        .M_mul_lo(c_lo), .M_mul_hi(c_hi), .M_mul_valid(c_mv));

    nios2_mult_cell_pipe #(.DATA_W(8), .MULT_STAGES(1)) dut_d (
        .clk(clk), .reset_n(reset_n), .E_src1(src1[7:0]), .E_src2(src2[7:0]), .E_valid(e_valid),
        .E_signed_a(sa), .E_signed_b(sb), .M_en(m_en), .M_flush(m_flush),
        .M_mul_cell_p1(d_p1), .M_mul_cell_p2(d_p2), .M_mul_cell_p3(d_p3), .M_pp_valid(d_ppv),
        .M_mul_lo(d_lo), .M_mul_hi(d_hi), .M_mul_valid(d_mv));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full product of the extended operands, truncated to 2*w bits.
    function automatic logic [63:0] ref_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic fa, input logic fb, input int w);
        logic [31:0] am, bm;
        longint      ea, eb, p;
        logic [63:0] r;
        am = a; bm = b;
        if (w < 32) begin
            am = a & ((32'd1 << w) - 32'd1);
            bm = b & ((32'd1 << w) - 32'd1);
        end
        ea = longint'({32'd0, am});
        eb = longint'({32'd0, bm});
        if (fa && am[w-1]) ea = ea - (longint'(1) << w);
        if (fb && bm[w-1]) eb = eb - (longint'(1) << w);
        p = ea * eb;
        r = p;
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    function automatic logic [31:0] ref_pp(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input int k);
        int          h;
        logic [31:0] hm, al, ah, bl, bh;
        h  = w / 2;
        hm = (32'd1 << h) - 32'd1;
        al = a & hm;  ah = (a >> h) & hm;
        bl = b & hm;  bh = (b >> h) & hm;
        if (k == 1) return al * bl;
        if (k == 2) return al * bh;
        return ah * bl;
    endfunction

    // Driver tasks
    task automatic drive_idle();
        e_valid = 1'b0; m_en = 1'b1; m_flush = 1'b0; sa = 1'b0; sb = 1'b0;
        src1 = '0; src2 = '0;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic fa, input logic fb);
        src1 = a; src2 = b; sa = fa; sb = fb; e_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        src1 = 32'h1234_5678; src2 = 32'h9abc_def0; e_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (a_p1 !== 32'h0) begin n_fail++; $display("FAIL reset_p1 got=%h exp=0", a_p1); end
        n_checks++; if (a_p2 !== 32'h0) begin n_fail++; $display("FAIL reset_p2 got=%h exp=0", a_p2); end
        n_checks++; if (a_p3 !== 32'h0) begin n_fail++; $display("FAIL reset_p3 got=%h exp=0", a_p3); end
        n_checks++; if (a_lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", a_lo); end
        n_checks++; if (a_hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", a_hi); end
        n_checks++; if (a_ppv !== 1'b0) begin n_fail++; $display("FAIL reset_ppv got=%b exp=0", a_ppv); end
        n_checks++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL reset_mv got=%b exp=0", a_mv); end
        n_checks++; if (c_mv !== 1'b0) begin n_fail++; $display("FAIL reset_c_mv got=%b exp=0", c_mv); end
        drive_idle();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        drive_op(32'h0001_0003, 32'h0002_0005, 1'b0, 1'b0);
        tick();
        e_valid = 1'b0;
        n_checks++; if (a_p1 !== 32'h0000_000F) begin n_fail++; $display("FAIL unsigned_p1 got=%h exp=0000000f", a_p1); end
        n_checks++; if (a_p2 !== 32'h0000_0006) begin n_fail++; $display("FAIL unsigned_p2 got=%h exp=00000006", a_p2); end
        n_checks++; if (a_p3 !== 32'h0000_0005) begin n_fail++; $display("FAIL unsigned_p3 got=%h exp=00000005", a_p3); end
        n_checks++; if (a_ppv !== 1'b1) begin n_fail++; $display("FAIL unsigned_ppv got=%b exp=1", a_ppv); end
        tick();
        n_checks++; if (a_hi !== 32'h0000_0002) begin n_fail++; $display("FAIL unsigned_hi got=%h exp=00000002", a_hi); end
        n_checks++; if (a_lo !== 32'h000B_000F) begin n_fail++; $display("FAIL unsigned_lo got=%h exp=000b000f", a_lo); end
        n_checks++; if (a_mv !== 1'b1) begin n_fail++; $display("FAIL unsigned_mv got=%b exp=1", a_mv); end
        tick();
        n_checks++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL unsigned_mv_drop got=%b exp=0", a_mv); end
    endtask

    task automatic test_sign_modes();
        logic [1:0]  fl [3];
        logic [31:0] exp_hi [3];
        fl = '{2'b11, 2'b00, 2'b10};
        exp_hi = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc < 3) drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, fl[cyc][1], fl[cyc][0]);
            else e_valid = 1'b0;
            tick();
            if (cyc >= 1) begin
                n_checks++; if (a_mv !== 1'b1) begin n_fail++; $display("FAIL sign_mv op%0d got=%b exp=1", cyc - 1, a_mv); end
                n_checks++; if (a_hi !== exp_hi[cyc-1]) begin n_fail++; $display("FAIL sign_hi op%0d got=%h exp=%h", cyc - 1, a_hi, exp_hi[cyc-1]); end
                n_checks++; if (a_lo !== 32'h0000_0001) begin n_fail++; $display("FAIL sign_lo op%0d got=%h exp=00000001", cyc - 1, a_lo); end
            end
        end
        tick();
    endtask

    task automatic test_flush();
        drive_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        tick();
        drive_op(32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
        tick();
        n_checks++; if (a_lo !== 32'h0000_0200) begin n_fail++; $display("FAIL flush_pre_lo got=%h exp=00000200", a_lo); end
        n_checks++; if (a_ppv !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ppv got=%b exp=1", a_ppv); end
        drive_op(32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0);
        m_flush = 1'b1; m_en = 1'b0;
        tick();
        m_flush = 1'b0; m_en = 1'b1; e_valid = 1'b0;
        n_checks++; if (a_ppv !== 1'b0) begin n_fail++; $display("FAIL flush_ppv got=%b exp=0", a_ppv); end
        n_checks++; if (a_mv !== 1'b0) begin n_fail++; $display("FAIL flush_mv got=%b exp=0", a_mv); end
        n_checks++; if (c_ppv !== 1'b0 || c_mv !== 1'b0) begin n_fail++; $display("FAIL flush_c_valid got=%b%b exp=00", c_ppv, c_mv); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (a_ppv !== 1'b0 || a_mv !== 1'b0) begin n_fail++; $display("FAIL flush_ghost edge%0d got=%b%b exp=00", k, a_ppv, a_mv); end
        end
        drive_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
        tick();
        e_valid = 1'b0;
        n_checks++; if (a_ppv !== 1'b1) begin n_fail++; $display("FAIL flush_clean_ppv got=%b exp=1", a_ppv); end
        tick();
        n_checks++; if (a_mv !== 1'b1) begin n_fail++; $display("FAIL flush_clean_mv got=%b exp=1", a_mv); end
        n_checks++; if (a_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_clean_hi got=%h exp=ffffffff", a_hi); end
        n_checks++; if (a_lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL flush_clean_lo got=%h exp=fffffffe", a_lo); end
    endtask

    task automatic test_reset_mid();
        drive_op(32'h0000_00FF, 32'h0000_0101, 1'b0, 1'b0);
        tick();
        drive_op(32'h0003_0000, 32'h0005_0000, 1'b0, 1'b0);
        tick();
        e_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (a_p1 !== 32'h0 || a_p2 !== 32'h0 || a_p3 !== 32'h0) begin n_fail++; $display("FAIL rstmid_pp got=%h/%h/%h exp=0", a_p1, a_p2, a_p3); end
        n_checks++; if (a_lo !== 32'h0 || a_hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_lohi got=%h/%h exp=0", a_hi, a_lo); end
        n_checks++; if (a_ppv !== 1'b0 || a_mv !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b%b exp=00", a_ppv, a_mv); end
        n_checks++; if (c_ppv !== 1'b0 || c_mv !== 1'b0) begin n_fail++; $display("FAIL rstmid_c_valid got=%b%b exp=00", c_ppv, c_mv); end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src1 = $urandom; src2 = $urandom;
            tick();
            n_checks++; if (a_ppv !== 1'b0 || a_mv !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_valid edge%0d got=%b%b exp=00", k, a_ppv, a_mv); end
            n_checks++; if (a_p1 !== 32'h0 || a_lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_post_data edge%0d got=%h/%h exp=0", k, a_p1, a_lo); end
        end
        drive_idle();
    endtask

    task automatic test_stall();
        bit          en_t  [10];
        bit          iss_t [10];
        bit          exp_v [10];
        en_t  = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        iss_t = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        exp_v = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int k = 0; k < 10; k++) begin
            m_en = en_t[k];
            if (iss_t[k] && k == 0) drive_op(32'h0003_0007, 32'hFFFF_FFFD, 1'b1, 1'b1);
            else if (iss_t[k]) drive_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
            else e_valid = 1'b0;
            tick();
            n_checks++; if (b_mv !== exp_v[k]) begin n_fail++; $display("FAIL stall_mv edge%0d got=%b exp=%b", k, b_mv, exp_v[k]); end
            if (k >= 5 && k <= 7) begin
                n_checks++; if (b_hi !== 32'hFFFF_FFFF || b_lo !== 32'hFFF6_FFEB) begin n_fail++; $display("FAIL stall_hold edge%0d got=%h_%h exp=ffffffff_fff6ffeb", k, b_hi, b_lo); end
            end
            if (k == 8) begin
                n_checks++; if (b_hi !== 32'h4000_0000 || b_lo !== 32'h0) begin n_fail++; $display("FAIL stall_second got=%h_%h exp=40000000_00000000", b_hi, b_lo); end
            end
        end
        drive_idle();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        fa;
        logic        fb;
        int          rem;
    } op_t;

    task automatic test_sweep();
        op_t         mq [3][$];
        int          stg [3];
        int          wid [3];
        logic [31:0] o_p1 [3], o_p2 [3], o_p3 [3], o_lo [3], o_hi [3];
        logic        o_ppv [3], o_mv [3];
        logic [31:0] msk;
        logic [63:0] full;
        bit          iss, en, ev_pp, ev_mv;
        op_t         opp, omv;
        int          issued, cyc;
        stg = '{1, 3, 1};
        wid = '{32, 16, 8};
        reset_n = 1'b0;
        drive_idle();
        tick();
        reset_n = 1'b1;
        tick();
        issued = 0;
        cyc = 0;
        while ((issued < 200 || cyc < 2000) && cyc < 2000) begin
            if (issued >= 200) begin
                if (cyc > 0 && mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0) break;
                e_valid = 1'b0; m_en = 1'b1;
            end else begin
                case ($urandom_range(0, 7))
                    0:       src1 = 32'hFFFF_FFFF;
                    1:       src1 = 32'h8000_8080;
                    default: src1 = $urandom;
                endcase
                case ($urandom_range(0, 7))
                    0:       src2 = 32'hFFFF_FFFF;
                    1:       src2 = 32'h8000_8080;
                    default: src2 = $urandom;
                endcase
                sa = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                e_valid = ($urandom_range(0, 9) < 9);
                m_en = ($urandom_range(0, 4) != 0);
            end
            iss = e_valid;
            en  = m_en;
            tick();
            cyc++;
            if (en && iss) issued++;
            o_p1[0] = a_p1;         o_p2[0] = a_p2;         o_p3[0] = a_p3;
            o_lo[0] = a_lo;         o_hi[0] = a_hi;         o_ppv[0] = a_ppv; o_mv[0] = a_mv;
            o_p1[1] = {16'd0, c_p1}; o_p2[1] = {16'd0, c_p2}; o_p3[1] = {16'd0, c_p3};
            o_lo[1] = {16'd0, c_lo}; o_hi[1] = {16'd0, c_hi}; o_ppv[1] = c_ppv; o_mv[1] = c_mv;
            o_p1[2] = {24'd0, d_p1}; o_p2[2] = {24'd0, d_p2}; o_p3[2] = {24'd0, d_p3};
            o_lo[2] = {24'd0, d_lo}; o_hi[2] = {24'd0, d_hi}; o_ppv[2] = d_ppv; o_mv[2] = d_mv;
            for (int d = 0; d < 3; d++) begin
                if (en) begin
                    for (int i = 0; i < mq[d].size(); i++) mq[d][i].rem = mq[d][i].rem - 1;
                    while (mq[d].size() > 0 && mq[d][0].rem < 0) void'(mq[d].pop_front());
                    if (iss) mq[d].push_back('{a: src1, b: src2, fa: sa, fb: sb, rem: stg[d]});
                end
                ev_pp = 1'b0; ev_mv = 1'b0;
                opp = '{a: 0, b: 0, fa: 0, fb: 0, rem: 0};
                omv = opp;
                for (int i = 0; i < mq[d].size(); i++) begin
                    if (mq[d][i].rem == 1) begin ev_pp = 1'b1; opp = mq[d][i]; end
                    if (mq[d][i].rem == 0) begin ev_mv = 1'b1; omv = mq[d][i]; end
                end
                msk = (wid[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[d]) - 32'd1);
                n_checks++; if (o_ppv[d] !== ev_pp) begin n_fail++; $display("FAIL sweep_ppv dut%0d cyc%0d got=%b exp=%b", d, cyc, o_ppv[d], ev_pp); end
                n_checks++; if (o_mv[d] !== ev_mv) begin n_fail++; $display("FAIL sweep_mv dut%0d cyc%0d got=%b exp=%b", d, cyc, o_mv[d], ev_mv); end
                if (ev_pp) begin
                    n_checks++;
                    if (o_p1[d] !== ref_pp(opp.a, opp.b, wid[d], 1) || o_p2[d] !== ref_pp(opp.a, opp.b, wid[d], 2) ||
                        o_p3[d] !== ref_pp(opp.a, opp.b, wid[d], 3)) begin
                        n_fail++;
                        $display("FAIL sweep_pp dut%0d cyc%0d got=%h/%h/%h exp=%h/%h/%h", d, cyc, o_p1[d], o_p2[d], o_p3[d],
                                 ref_pp(opp.a, opp.b, wid[d], 1), ref_pp(opp.a, opp.b, wid[d], 2), ref_pp(opp.a, opp.b, wid[d], 3));
                    end
                end
                if (ev_mv) begin
                    full = ref_full(omv.a, omv.b, omv.fa, omv.fb, wid[d]);
                    n_checks++;
                    if (o_lo[d] !== (full[31:0] & msk) || o_hi[d] !== (32'(full >> wid[d]) & msk)) begin
                        n_fail++;
                        $display("FAIL sweep_prod dut%0d cyc%0d got=%h_%h exp=%h_%h", d, cyc, o_hi[d], o_lo[d],
                                 32'(full >> wid[d]) & msk, full[31:0] & msk);
                    end
                end
            end
        end
        n_checks++; if (issued < 200) begin n_fail++; $display("FAIL sweep_issue_count got=%0d exp>=200", issued); end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;
        test_reset();
        test_unsigned();
        test_sign_modes();
        test_flush();
        test_reset_mid();
        test_stall();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
